// File: rtl/tl_mem_model.sv
// TileLink-C slave memory model: backing store, multi-beat A/C/D bursts, D backpressure,
// GrantAck wait and a protected region. Define TL_MEM_PROT_DENY_EN to deny protected hits.
module tl_mem_model #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 256,
    parameter int                SRC_W     = 4,
    parameter int                MAX_SIZE  = 6,
    parameter logic [ADDR_W-1:0] PROT_BASE = 32'h8abcde00,
    parameter logic [ADDR_W-1:0] PROT_MASK = 32'hffffffc0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DATA_W-1:0]   secret,
    output logic                a_ready,
    input  logic                a_valid,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [3:0]          a_size,
    input  logic [SRC_W-1:0]    a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    output logic                c_ready,
    input  logic                c_valid,
    input  logic [2:0]          c_opcode,
    input  logic [3:0]          c_size,
    input  logic [SRC_W-1:0]    c_source,
    input  logic [ADDR_W-1:0]   c_address,
    input  logic [DATA_W-1:0]   c_data,
    input  logic                d_ready,
    output logic                d_valid,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [3:0]          d_size,
    output logic [SRC_W-1:0]    d_source,
    output logic [2:0]          d_sink,
    output logic [DATA_W-1:0]   d_data,
    output logic                d_error,
    output logic                e_ready,
    input  logic                e_valid,
    input  logic [2:0]          e_sink
);

    localparam int OFF     = $clog2(DATA_W / 8);
    localparam int IDXW    = $clog2(DEPTH);
    localparam int MAX_LOG = (MAX_SIZE > OFF) ? MAX_SIZE - OFF : 0;
    localparam int CNT_W   = MAX_LOG + 1;

    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_HINT_ACK        = 3'd2;
    localparam logic [2:0] D_GRANT           = 3'd4;
    localparam logic [2:0] D_GRANT_DATA      = 3'd5;
    localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

    typedef enum logic [2:0] {IDLE, A_WR, C_WR, RESP, WAIT_E} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [CNT_W-1:0]    rsp_last_q, rsp_last_d;
    logic [2:0]          d_opcode_q, d_opcode_d;
    logic [1:0]          d_param_q, d_param_d;
    logic [3:0]          size_q, size_d;
    logic [SRC_W-1:0]    source_q, source_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                err_q, err_d;
    logic                grant_q, grant_d;
    logic                data_q, data_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_en;
    logic [IDXW-1:0]     wr_idx;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_mask;

    logic                a_err, c_err, a_deny, c_deny;
    logic [CNT_W-1:0]    a_last, c_last;

    logic unused_e_sink;
    assign unused_e_sink = ^e_sink;

    function automatic logic [CNT_W-1:0] last_beat(input logic [3:0] size);
        int sz;
        sz = int'(size);
        if (sz > OFF && sz <= MAX_SIZE) return CNT_W'((1 << (sz - OFF)) - 1);
        return '0;
    endfunction

    function automatic logic [IDXW-1:0] word_idx(input logic [ADDR_W-1:0] addr,
                                                 input logic [CNT_W-1:0]  beat);
        return addr[OFF +: IDXW] + IDXW'(beat);
    endfunction

    function automatic logic prot_hit(input logic [ADDR_W-1:0] addr,
                                      input logic [CNT_W-1:0]  beat);
        logic [ADDR_W-1:0] beat_addr;
        beat_addr = addr + (ADDR_W'(beat) << OFF);
        return (beat_addr & PROT_MASK) == PROT_BASE;
    endfunction

    assign a_ready  = (state_q == IDLE && !c_valid) || state_q == A_WR;
    assign c_ready  = state_q == IDLE || state_q == C_WR;
    assign d_valid  = state_q == RESP;
    assign e_ready  = state_q == WAIT_E;
    assign d_opcode = d_opcode_q;
    assign d_param  = d_param_q;
    assign d_size   = size_q;
    assign d_source = source_q;
    assign d_sink   = 3'd0;
    assign d_error  = err_q;

    // Denied and error responses carry zero data; otherwise protected beats leak the secret.
    always_comb begin
        d_data = '0;
        if (data_q && !err_q) begin
            d_data = prot_hit(addr_q, beat_q) ? secret : mem_q[word_idx(addr_q, beat_q)];
        end
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        rsp_last_d = rsp_last_q;
        d_opcode_d = d_opcode_q;
        d_param_d  = d_param_q;
        size_d     = size_q;
        source_d   = source_q;
        addr_d     = addr_q;
        err_d      = err_q;
        grant_d    = grant_q;
        data_d     = data_q;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_data    = '0;
        wr_mask    = '0;

`ifdef TL_MEM_PROT_DENY_EN
        a_deny = prot_hit(a_address, '0);
        c_deny = prot_hit(c_address, '0);
`else
        a_deny = 1'b0;
        c_deny = 1'b0;
`endif
        a_err  = (a_opcode == 3'd7) || (int'(a_size) > MAX_SIZE) || a_deny;
        c_err  = (int'(c_size) > MAX_SIZE) || c_deny;
        a_last = (a_err && !a_deny) ? '0 : last_beat(a_size);
        c_last = (c_err && !c_deny) ? '0 : last_beat(c_size);

        case (state_q)
            IDLE: begin
                if (c_valid) begin
                    source_d   = c_source;
                    size_d     = c_size;
                    addr_d     = c_address;
                    err_d      = c_err;
                    d_opcode_d = D_RELEASE_ACK;
                    d_param_d  = 2'd0;
                    data_d     = 1'b0;
                    grant_d    = 1'b0;
                    rsp_last_d = '0;
                    beat_d     = '0;
                    if (c_opcode == 3'd6) begin
                        state_d = RESP;
                    end else if (c_opcode == 3'd7) begin
                        wr_en   = !c_err && !prot_hit(c_address, '0);
                        wr_idx  = word_idx(c_address, '0);
                        wr_data = c_data;
                        wr_mask = '1;
                        if (c_last != '0) begin
                            state_d = C_WR;
                            beat_d  = CNT_W'(1);
                        end else begin
                            state_d = RESP;
                        end
                    end
                end else if (a_valid) begin
                    source_d   = a_source;
                    size_d     = a_size;
                    addr_d     = a_address;
                    err_d      = a_err;
                    d_param_d  = 2'd0;
                    data_d     = 1'b0;
                    grant_d    = 1'b0;
                    rsp_last_d = '0;
                    beat_d     = '0;
                    state_d    = RESP;
                    case (a_opcode)
                        3'd0, 3'd1: begin
                            d_opcode_d = D_ACCESS_ACK;
                            wr_en      = !a_err && !prot_hit(a_address, '0);
                            wr_idx     = word_idx(a_address, '0);
                            wr_data    = a_data;
                            wr_mask    = a_mask;
                            if (a_last != '0) begin
                                state_d = A_WR;
                                beat_d  = CNT_W'(1);
                            end
                        end
                        3'd2, 3'd3, 3'd4: begin
                            d_opcode_d = D_ACCESS_ACK_DATA;
                            rsp_last_d = a_last;
                            data_d     = 1'b1;
                        end
                        3'd5: d_opcode_d = D_HINT_ACK;
                        3'd6: begin
                            grant_d = 1'b1;
                            if (a_param == 3'd0 || a_param == 3'd1) begin
                                d_opcode_d = D_GRANT_DATA;
                                d_param_d  = (a_param == 3'd0) ? 2'd1 : 2'd0;
                                rsp_last_d = a_last;
                                data_d     = 1'b1;
                            end else begin
                                d_opcode_d = D_GRANT;
                            end
                        end
                        default: d_opcode_d = D_ACCESS_ACK;
                    endcase
                end
            end
            A_WR: begin
                if (a_valid) begin
                    wr_en   = !err_q && !prot_hit(addr_q, beat_q);
                    wr_idx  = word_idx(addr_q, beat_q);
                    wr_data = a_data;
                    wr_mask = a_mask;
                    if (beat_q == last_beat(size_q)) begin
                        state_d = RESP;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            C_WR: begin
                if (c_valid) begin
                    wr_en   = !err_q && !prot_hit(addr_q, beat_q);
                    wr_idx  = word_idx(addr_q, beat_q);
                    wr_data = c_data;
                    wr_mask = '1;
                    if (beat_q == last_beat(size_q)) begin
                        state_d = RESP;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            RESP: begin
                if (d_ready) begin
                    if (beat_q == rsp_last_q) begin
                        beat_d  = '0;
                        state_d = grant_q ? WAIT_E : IDLE;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            WAIT_E: begin
                if (e_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            rsp_last_q <= '0;
            d_opcode_q <= 3'd0;
            d_param_q  <= 2'd0;
            size_q     <= 4'd0;
            source_q   <= '0;
            addr_q     <= '0;
            err_q      <= 1'b0;
            grant_q    <= 1'b0;
            data_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            rsp_last_q <= rsp_last_d;
            d_opcode_q <= d_opcode_d;
            d_param_q  <= d_param_d;
            size_q     <= size_d;
            source_q   <= source_d;
            addr_q     <= addr_d;
            err_q      <= err_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
        end
    end

    // NOTE: the store is deliberately not reset; a reset cycle only blocks the write in flight.
    always_ff @(posedge clock) begin
        if (!reset && wr_en) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wr_mask[b]) mem_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_tl_mem_model.sv
// Directed self-checking bench for tl_mem_model; expectations follow TL_MEM_PROT_DENY_EN.
module tb_tl_mem_model;

`ifdef TL_MEM_PROT_DENY_EN
    localparam logic DENY = 1'b1;
`else
    localparam logic DENY = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] secret;
    logic        a_ready, a_valid;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [3:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        c_ready, c_valid;
    logic [2:0]  c_opcode;
    logic [3:0]  c_size;
    logic [3:0]  c_source;
    logic [31:0] c_address;
    logic [63:0] c_data;
    logic        d_ready, d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [3:0]  d_source;
    logic [2:0]  d_sink;
    logic [63:0] d_data;
    logic        d_error;
    logic        e_ready, e_valid;
    logic [2:0]  e_sink;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    tl_mem_model dut (
        .clock(clock), .reset(reset), .secret(secret),
        .a_ready(a_ready), .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data),
        .c_ready(c_ready), .c_valid(c_valid), .c_opcode(c_opcode), .c_size(c_size),
        .c_source(c_source), .c_address(c_address), .c_data(c_data),
        .d_ready(d_ready), .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param),
        .d_size(d_size), .d_source(d_source), .d_sink(d_sink), .d_data(d_data),
        .d_error(d_error),
        .e_ready(e_ready), .e_valid(e_valid), .e_sink(e_sink)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [2:0] prm, input logic [3:0] sz,
                          input logic [3:0] src, input logic [31:0] addr,
                          input logic [7:0] mask, input logic [63:0] data, input string tag);
        int n = 0;
        a_opcode = op; a_param = prm; a_size = sz; a_source = src;
        a_address = addr; a_mask = mask; a_data = data; a_valid = 1'b1;
        #1;
        while (a_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_a_accept"}, 64'(n < 50), 64'd1);
        tick();
        a_valid = 1'b0;
    endtask

    task automatic send_c(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                          input logic [31:0] addr, input logic [63:0] data, input string tag);
        int n = 0;
        c_opcode = op; c_size = sz; c_source = src; c_address = addr; c_data = data;
        c_valid = 1'b1;
        #1;
        while (c_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_c_accept"}, 64'(n < 50), 64'd1);
        tick();
        c_valid = 1'b0;
    endtask

    task automatic recv_d(input string tag, input logic [2:0] op, input logic [1:0] prm,
                          input logic [3:0] src, input logic [3:0] sz, input logic err,
                          input logic data_en, input logic [63:0] data);
        int n = 0;
        d_ready = 1'b1;
        #1;
        while (d_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_d_valid"}, 64'(n < 50), 64'd1);
        check({tag, "_opcode"}, d_opcode, op);
        check({tag, "_param"}, d_param, prm);
        check({tag, "_source"}, d_source, src);
        check({tag, "_size"}, d_size, sz);
        check({tag, "_error"}, d_error, err);
        if (data_en) check({tag, "_data"}, d_data, data);
        tick();
        d_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beat;
        int cyc;
        reset = 1'b1; secret = 64'h5EC2E7;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0;
        c_valid = 1'b0; c_opcode = '0; c_size = '0; c_source = '0; c_address = '0; c_data = '0;
        d_ready = 1'b0; e_valid = 1'b0; e_sink = '0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_d_valid", d_valid, 1'b0);
        check("rst_e_ready", e_ready, 1'b0);
        check("rst_a_ready", a_ready, 1'b1);
        check("rst_c_ready", c_ready, 1'b1);

        // PutFull / Get round trip, then a PutPartial merge
        send_a(3'd0, 3'd0, 4'd3, 4'd1, 32'h100, 8'hff, 64'hDEADBEEF_01234567, "put");
        recv_d("put_ack", 3'd0, 2'd0, 4'd1, 4'd3, 1'b0, 1'b0, 64'h0);
        send_a(3'd4, 3'd0, 4'd3, 4'd2, 32'h100, 8'hff, 64'h0, "get");
        recv_d("get", 3'd1, 2'd0, 4'd2, 4'd3, 1'b0, 1'b1, 64'hDEADBEEF_01234567);
        send_a(3'd1, 3'd0, 4'd3, 4'd3, 32'h100, 8'h0f, 64'hAAAAAAAA_55555555, "pput");
        recv_d("pput_ack", 3'd0, 2'd0, 4'd3, 4'd3, 1'b0, 1'b0, 64'h0);
        send_a(3'd4, 3'd0, 4'd3, 4'd4, 32'h100, 8'hff, 64'h0, "get2");
        recv_d("get2", 3'd1, 2'd0, 4'd4, 4'd3, 1'b0, 1'b1, 64'hDEADBEEF_55555555);

        // 8-beat PutFull burst, then Acquire NtoB with d_ready pattern 1,0,1
        for (int i = 0; i < 8; i++)
            send_a(3'd0, 3'd0, 4'd6, 4'd1, 32'h200, 8'hff, 64'h1000 + 64'(i), "burst_put");
        recv_d("burst_ack", 3'd0, 2'd0, 4'd1, 4'd6, 1'b0, 1'b0, 64'h0);
        send_a(3'd6, 3'd0, 4'd6, 4'd3, 32'h200, 8'hff, 64'h0, "acq");
        beat = 0;
        cyc = 0;
        while (beat < 8 && cyc < 100) begin
            d_ready = (cyc % 3) != 1;
            #1;
            check("gd_valid", d_valid, 1'b1);
            check("gd_opcode", d_opcode, 3'd5);
            check("gd_param", d_param, 2'd1);
            check("gd_data", d_data, 64'h1000 + 64'(beat));
            if (d_ready) beat++;
            tick();
            cyc++;
        end
        check("gd_beats", 64'(beat), 64'd8);
        d_ready = 1'b0;
        #1;
        check("gd_e_ready", e_ready, 1'b1);
        check("gd_d_valid_done", d_valid, 1'b0);
        check("gd_a_ready_wait", a_ready, 1'b0);
        tick();
        check("gd_e_ready_hold", e_ready, 1'b1);
        e_valid = 1'b1;
        tick();
        e_valid = 1'b0;
        #1;
        check("gd_a_ready_after_e", a_ready, 1'b1);
        check("gd_e_ready_after_e", e_ready, 1'b0);

        // Acquire BtoT gives a dataless Grant and still waits for GrantAck
        send_a(3'd6, 3'd2, 4'd3, 4'd8, 32'h100, 8'hff, 64'h0, "btot");
        recv_d("grant", 3'd4, 2'd0, 4'd8, 4'd3, 1'b0, 1'b0, 64'h0);
        #1;
        check("grant_e_ready", e_ready, 1'b1);
        e_valid = 1'b1;
        tick();
        e_valid = 1'b0;

        // Intent -> HintAck
        send_a(3'd5, 3'd0, 4'd3, 4'd4, 32'h100, 8'hff, 64'h0, "hint");
        recv_d("hint", 3'd2, 2'd0, 4'd4, 4'd3, 1'b0, 1'b0, 64'h0);

        // A and C together: C wins, A waits for the ReleaseAck to drain
        a_opcode = 3'd4; a_param = 3'd0; a_size = 4'd3; a_source = 4'd5;
        a_address = 32'h100; a_mask = 8'hff; a_valid = 1'b1;
        c_opcode = 3'd6; c_size = 4'd3; c_source = 4'd6; c_address = 32'h300; c_valid = 1'b1;
        #1;
        check("both_a_ready", a_ready, 1'b0);
        check("both_c_ready", c_ready, 1'b1);
        tick();
        c_valid = 1'b0;
        #1;
        check("rel_a_ready_resp", a_ready, 1'b0);
        recv_d("rel_ack", 3'd6, 2'd0, 4'd6, 4'd3, 1'b0, 1'b0, 64'h0);
        #1;
        check("rel_a_ready_idle", a_ready, 1'b1);
        send_a(3'd4, 3'd0, 4'd3, 4'd5, 32'h100, 8'hff, 64'h0, "get3");
        recv_d("get3", 3'd1, 2'd0, 4'd5, 4'd3, 1'b0, 1'b1, 64'hDEADBEEF_55555555);

        // Protected region: 0x608 aliases the same store word as 0x8abcde08
        send_a(3'd0, 3'd0, 4'd3, 4'd1, 32'h608, 8'hff, 64'h01234567_89ABCDEF, "alias_put");
        recv_d("alias_ack", 3'd0, 2'd0, 4'd1, 4'd3, 1'b0, 1'b0, 64'h0);
        send_a(3'd0, 3'd0, 4'd3, 4'd1, 32'h8abcde08, 8'hff, 64'hBAD0BAD0_BAD0BAD0, "prot_put");
        recv_d("prot_put_ack", 3'd0, 2'd0, 4'd1, 4'd3, DENY, 1'b0, 64'h0);
        send_a(3'd4, 3'd0, 4'd3, 4'd2, 32'h8abcde08, 8'hff, 64'h0, "prot_get");
        recv_d("prot_get", 3'd1, 2'd0, 4'd2, 4'd3, DENY, 1'b1, DENY ? 64'h0 : 64'h5EC2E7);
        send_a(3'd4, 3'd0, 4'd3, 4'd2, 32'h608, 8'hff, 64'h0, "alias_get");
        recv_d("alias_get", 3'd1, 2'd0, 4'd2, 4'd3, 1'b0, 1'b1, 64'h01234567_89ABCDEF);

        // Oversized Get -> single errored AccessAckData beat
        send_a(3'd4, 3'd0, 4'd7, 4'd9, 32'h100, 8'hff, 64'h0, "big_get");
        recv_d("big_get", 3'd1, 2'd0, 4'd9, 4'd7, 1'b1, 1'b1, 64'h0);
        #1;
        check("big_get_d_valid", d_valid, 1'b0);
        check("big_get_a_ready", a_ready, 1'b1);

        // Reset on the third beat of an 8-beat ReleaseData
        send_a(3'd0, 3'd0, 4'd3, 4'd1, 32'h410, 8'hff, 64'h77, "pre_put");
        recv_d("pre_ack", 3'd0, 2'd0, 4'd1, 4'd3, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 2; i++)
            send_c(3'd7, 4'd6, 4'd7, 32'h400, 64'hC0 + 64'(i), "rdata");
        c_data = 64'hC2;
        c_valid = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        c_valid = 1'b0;
        #1;
        check("mid_rst_d_valid", d_valid, 1'b0);
        check("mid_rst_a_ready", a_ready, 1'b1);
        check("mid_rst_e_ready", e_ready, 1'b0);
        send_a(3'd4, 3'd0, 4'd4, 4'd2, 32'h400, 8'hff, 64'h0, "rd_after_rst");
        recv_d("rd_b0", 3'd1, 2'd0, 4'd2, 4'd4, 1'b0, 1'b1, 64'hC0);
        recv_d("rd_b1", 3'd1, 2'd0, 4'd2, 4'd4, 1'b0, 1'b1, 64'hC1);
        send_a(3'd4, 3'd0, 4'd3, 4'd2, 32'h410, 8'hff, 64'h0, "rd_b2_get");
        recv_d("rd_b2", 3'd1, 2'd0, 4'd2, 4'd3, 1'b0, 1'b1, 64'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
